vpi_request_arbiter: RTL and testbench

VPI_REQUEST_ARBITER -- requirements
Module: vpi_request_arbiter

---
 rtl/vpi_request_arbiter.sv | 136 +++++++++++++
 tb/tb_vpi_request_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vpi_request_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ VPI queries onto one bridge, one query in flight.
// Grant to response is 3 cycles minimum; req_ready only in IDLE, br_valid held until br_ready.
module vpi_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*OP_W-1:0]    req_op,
  input  logic [NUM_REQ*DATA_W-1:0]  req_handle,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       br_valid,
  input  logic                       br_ready,
  output logic [OP_W-1:0]            br_op,
  output logic [DATA_W-1:0]          br_handle,
  input  logic                       br_rsp_valid,
  input  logic [DATA_W-1:0]          br_rsp_data,
  input  logic                       br_rsp_err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [7:0]                 drop_cnt
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [15:0]        WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   prio_ptr;
  logic [15:0]       wait_cnt;

  logic              gnt_any;
  logic [ID_W-1:0]   gnt_idx;
  logic [OP_W-1:0]   gnt_op;
  logic [DATA_W-1:0] gnt_handle;
  int                idx;

  // First valid requester scanning upward from prio_ptr, wrapping at NUM_REQ.
  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    gnt_op     = '0;
    gnt_handle = '0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(prio_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any    = 1'b1;
        gnt_idx    = ID_W'(idx);
        gnt_op     = req_op[idx*OP_W +: OP_W];
        gnt_handle = req_handle[idx*DATA_W +: DATA_W];
      end
    end
  end

  // The accept strobe must land in the same cycle as the sampled request.
  assign req_ready = (state == IDLE && !rst && gnt_any) ? (ONE << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio_ptr  <= '0;
      wait_cnt  <= '0;
      drop_cnt  <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      br_valid  <= 1'b0;
      br_op     <= '0;
      br_handle <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;

      // Only WAIT consumes bridge responses; anything else is late or spurious.
      if (br_rsp_valid && state != WAIT && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (gnt_any) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            grant_id  <= gnt_idx;
            br_valid  <= 1'b1;
            br_op     <= gnt_op;
            br_handle <= gnt_handle;
            prio_ptr  <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
          end
        end
        ISSUE: begin
          if (br_ready) begin
            state    <= WAIT;
            br_valid <= 1'b0;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          // A response in the final WAIT cycle beats the timeout.
          if (br_rsp_valid) begin
            state     <= RESP;
            rsp_valid <= ONE << grant_id;
            rsp_data  <= br_rsp_data;
            rsp_err   <= br_rsp_err;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= RESP;
            rsp_valid <= ONE << grant_id;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          state    <= IDLE;
          busy     <= 1'b0;
          grant_id <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vpi_request_arbiter.sv
// Randomized plus directed bench for vpi_request_arbiter against a transaction-level model.
module tb_vpi_request_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int TO = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_ready, rsp_valid;
  logic [NR*OW-1:0] req_op;
  logic [NR*DW-1:0] req_handle;
  logic [DW-1:0]   rsp_data, br_handle, br_rsp_data;
  logic            rsp_err, br_valid, br_ready, br_rsp_valid, br_rsp_err, busy;
  logic [OW-1:0]   br_op;
  logic [1:0]      grant_id;
  logic [7:0]      drop_cnt;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  int m_drop = 0;

  vpi_request_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_handle(req_handle),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op), .br_handle(br_handle),
    .br_rsp_valid(br_rsp_valid), .br_rsp_data(br_rsp_data), .br_rsp_err(br_rsp_err),
    .busy(busy), .grant_id(grant_id), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int g);
    logic [NR-1:0] one;
    one = NR'(1);
    return one << g;
  endfunction

  // Round-robin rule: first valid requester at or after the pointer, wrapping.
  function automatic int pick(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++)
      if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  // rsp_dly: WAIT cycle (1-based) in which the bridge answers; 0 or >TO means never.
  task automatic do_txn(input logic [NR-1:0] v, input int rdy_dly, input int rsp_dly,
                        input logic [DW-1:0] dat, input logic er, input bit noise,
                        input bit fix, input logic [OW-1:0] fop, input logic [DW-1:0] fh);
    int g, nwait;
    logic [OW-1:0] op;
    logic [DW-1:0] h, exp_d;
    logic exp_e;
    g = pick(v);
    @(negedge clk);
    req_valid = v;
    for (int i = 0; i < NR; i++) begin
      req_op[i*OW +: OW]     = OW'($urandom);
      req_handle[i*DW +: DW] = DW'($urandom);
    end
    if (fix) begin
      req_op[g*OW +: OW]     = fop;
      req_handle[g*DW +: DW] = fh;
    end
    op = req_op[g*OW +: OW];
    h  = req_handle[g*DW +: DW];
    #1;
    check_eq("idle_busy", 64'(busy), 64'(0));
    check_eq("idle_grant_id", 64'(grant_id), 64'(0));
    check_eq("idle_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("idle_rsp_data", 64'(rsp_data), 64'(0));
    check_eq("idle_rsp_err", 64'(rsp_err), 64'(0));
    check_eq("idle_drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check_eq("grant_req_ready", 64'(req_ready), 64'(oh(g)));
    m_ptr = (g + 1) % NR;

    for (int k = 0; k <= rdy_dly; k++) begin
      @(negedge clk);
      if (k == 0 && noise) req_valid = NR'($urandom);
      br_ready     = (k == rdy_dly);
      br_rsp_valid = noise ? 1'($urandom) : 1'b0;
      br_rsp_data  = DW'($urandom);
      if (br_rsp_valid) m_drop = sat_inc(m_drop);
      #1;
      check_eq("issue_br_valid", 64'(br_valid), 64'(1));
      check_eq("issue_br_op", 64'(br_op), 64'(op));
      check_eq("issue_br_handle", 64'(br_handle), 64'(h));
      check_eq("issue_grant_id", 64'(grant_id), 64'(g));
      check_eq("issue_req_ready", 64'(req_ready), 64'(0));
    end

    nwait = (rsp_dly >= 1 && rsp_dly <= TO) ? rsp_dly : TO;
    for (int w = 1; w <= nwait; w++) begin
      @(negedge clk);
      br_ready     = 1'b0;
      br_rsp_valid = (w == rsp_dly);
      br_rsp_data  = br_rsp_valid ? dat : DW'($urandom);
      br_rsp_err   = br_rsp_valid ? er : 1'($urandom);
      #1;
      check_eq("wait_br_valid", 64'(br_valid), 64'(0));
      check_eq("wait_rsp_valid", 64'(rsp_valid), 64'(0));
      check_eq("wait_busy", 64'(busy), 64'(1));
    end
    exp_d = (nwait == rsp_dly) ? dat : '0;
    exp_e = (nwait == rsp_dly) ? er : 1'b1;

    @(negedge clk);
    br_rsp_valid = 1'b0;
    br_rsp_err   = 1'b0;
    if (noise) req_valid = '0;
    #1;
    check_eq("resp_rsp_valid", 64'(rsp_valid), 64'(oh(g)));
    check_eq("resp_rsp_data", 64'(rsp_data), 64'(exp_d));
    check_eq("resp_rsp_err", 64'(rsp_err), 64'(exp_e));
    check_eq("resp_busy", 64'(busy), 64'(1));
  endtask

  task automatic idle_pulse(input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      req_valid    = '0;
      br_rsp_valid = 1'b0;
    end
    @(negedge clk);
    req_valid    = '0;
    br_rsp_valid = 1'b1;
    br_rsp_data  = DW'($urandom);
    m_drop       = sat_inc(m_drop);
    @(negedge clk);
    br_rsp_valid = 1'b0;
    #1;
    check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check_eq("drop_rsp_valid", 64'(rsp_valid), 64'(0));
  endtask

  task automatic reset_in_wait();
    int g;
    g = pick(4'b1000);
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    check_eq("rstw_grant", 64'(req_ready), 64'(oh(g)));
    @(negedge clk);
    req_valid = '0;
    br_ready  = 1'b1;
    @(negedge clk);
    br_ready = 1'b0;
    #1;
    check_eq("rstw_in_wait_busy", 64'(busy), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    m_ptr  = 0;
    m_drop = 0;
    #1;
    check_eq("rstw_busy", 64'(busy), 64'(0));
    check_eq("rstw_grant_id", 64'(grant_id), 64'(0));
    check_eq("rstw_br_valid", 64'(br_valid), 64'(0));
    check_eq("rstw_drop_cnt", 64'(drop_cnt), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_eq("rstw_no_rsp", 64'(rsp_valid), 64'(0));
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_handle = '0;
    br_ready = 1'b0; br_rsp_valid = 1'b0; br_rsp_data = '0; br_rsp_err = 1'b0;
    repeat (3) @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_grant_id", 64'(grant_id), 64'(0));
    check_eq("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    check_eq("rst_br_valid", 64'(br_valid), 64'(0));
    check_eq("rst_br_op", 64'(br_op), 64'(0));
    check_eq("rst_br_handle", 64'(br_handle), 64'(0));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_rsp_data", 64'(rsp_data), 64'(0));
    check_eq("rst_rsp_err", 64'(rsp_err), 64'(0));
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;

    // All four requesting continuously: grants rotate 0,1,2,3,0,1,2,3.
    for (int t = 0; t < 8; t++)
      do_txn(4'b1111, 0, 1, DW'($urandom), 1'b0, 1'b0, 1'b0, '0, '0);

    // Lone requester regranted back to back at minimum latency.
    for (int t = 0; t < 2; t++)
      do_txn(4'b0001, 0, 1, 32'h0000_BEEF, 1'b0, 1'b0, 1'b1, 4'd2, 32'h0000_1234);

    // Bridge silent: timeout after TO WAIT cycles, then a late answer is dropped.
    do_txn(4'b0010, 0, 0, 32'h1111_2222, 1'b0, 1'b0, 1'b0, '0, '0);
    idle_pulse(4);

    // Long br_ready stall does not time out.
    do_txn(4'b0100, 20, 3, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, '0, '0);

    // Answer in the very last WAIT cycle wins over the timeout.
    do_txn(4'b1000, 0, TO, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, '0, '0);
    do_txn(4'b1000, 1, TO, 32'h0BAD_CAFE, 1'b0, 1'b0, 1'b0, '0, '0);

    reset_in_wait();
    idle_pulse(0);
    do_txn(4'b1111, 0, 1, DW'($urandom), 1'b0, 1'b0, 1'b0, '0, '0);
    do_txn(4'b0100, 0, 2, DW'($urandom), 1'b1, 1'b0, 1'b0, '0, '0);

    for (int t = 0; t < 60; t++) begin
      do_txn(NR'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 12),
             DW'($urandom), 1'($urandom), 1'b1, 1'b0, '0, '0);
      if ($urandom_range(0, 4) == 0) idle_pulse($urandom_range(0, 3));
    end

    @(negedge clk);
    req_valid = '0;
    #1;
    check_eq("final_drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check_eq("final_busy", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
